// File: rtl/cu_pkg.sv
// Shared Control Unit definitions: front-end FSM states, execution group
// indices, RV opcode[6:2] values and trap causes.
package cu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH_REQ  = 3'd1,
      ST_FETCH_WAIT = 3'd2,
      ST_DISPATCH   = 3'd3,
      ST_EXEC_WAIT  = 3'd4,
      ST_TRAP       = 3'd5
   } state_t;

   // Execution FSM groups, one start bit each
   localparam int NUM_FSM       = 7;
   localparam int GRP_INT_REG   = 0;
   localparam int GRP_INT_IMM   = 1;
   localparam int GRP_LOAD      = 2;
   localparam int GRP_STORE     = 3;
   localparam int GRP_BRANCH    = 4;
   localparam int GRP_FLOAT     = 5;
   localparam int GRP_SYSTEM    = 6;

   // Instruction opcode bits [6:2]
   localparam logic [4:0] OPC_LOAD      = 5'b00000;
   localparam logic [4:0] OPC_LOAD_FP   = 5'b00001;
   localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC_STORE     = 5'b01000;
   localparam logic [4:0] OPC_STORE_FP  = 5'b01001;
   localparam logic [4:0] OPC_OP        = 5'b01100;
   localparam logic [4:0] OPC_LUI       = 5'b01101;
   localparam logic [4:0] OPC_OP_32     = 5'b01110;
   localparam logic [4:0] OPC_FMADD     = 5'b10000;
   localparam logic [4:0] OPC_FMSUB     = 5'b10001;
   localparam logic [4:0] OPC_FNMSUB    = 5'b10010;
   localparam logic [4:0] OPC_FNMADD    = 5'b10011;
   localparam logic [4:0] OPC_OP_FP     = 5'b10100;
   localparam logic [4:0] OPC_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC_JALR      = 5'b11001;
   localparam logic [4:0] OPC_JAL       = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
   localparam logic [1:0] CAUSE_FETCH_TO = 2'd2;
   localparam logic [1:0] CAUSE_EXEC_TO  = 2'd3;

endpackage

// File: rtl/fsm_fetch_dispatch_if.sv
// Fetch/dispatch bus between the front-end controller, instruction memory
// and the execution FSMs.
//
// Handshakes: mem_start is a one-cycle request; the memory answers with a
// one-cycle mem_done (mem_rdata valid in that cycle), no earlier than the
// cycle after mem_start. start is a one-hot one-cycle pulse; insn/code stay
// stable until the selected FSM returns a one-cycle fsm_done.
interface fsm_fetch_dispatch_if;
   import cu_pkg::*;

   logic                mem_start;
   logic [31:0]         mem_rdata;
   logic                mem_done;
   logic [NUM_FSM-1:0]  start;
   logic                fsm_done;
   logic [31:0]         insn;
   logic [31:0]         code;

   modport master (
      output mem_start, start, insn, code,
      input  mem_rdata, mem_done, fsm_done
   );

   modport slave (
      input  mem_start, start, insn, code,
      output mem_rdata, mem_done, fsm_done
   );

endinterface

// File: rtl/opcode_group_decode.sv
// Combinational opcode decode: one-hot code, execution group and illegal
// flag from insn[6:0]. Also used by the disassembly monitor.
module opcode_group_decode
   import cu_pkg::*;
(
   input  logic [6:0]          opcode,
   output logic [31:0]         code,
   output logic [NUM_FSM-1:0]  group,
   output logic                illegal
);

   // Map opcode[6:2] to its group; non-32-bit encodings have no group
   always_comb begin
      group = '0;
      case (opcode[6:2])
         OPC_OP, OPC_OP_32:                          group[GRP_INT_REG] = 1'b1;
         OPC_OP_IMM, OPC_OP_IMM_32,
         OPC_LUI, OPC_AUIPC:                         group[GRP_INT_IMM] = 1'b1;
         OPC_LOAD, OPC_LOAD_FP:                      group[GRP_LOAD]    = 1'b1;
         OPC_STORE, OPC_STORE_FP:                    group[GRP_STORE]   = 1'b1;
         OPC_BRANCH, OPC_JALR, OPC_JAL:              group[GRP_BRANCH]  = 1'b1;
         OPC_OP_FP, OPC_FMADD, OPC_FMSUB,
         OPC_FNMSUB, OPC_FNMADD:                     group[GRP_FLOAT]   = 1'b1;
         OPC_SYSTEM, OPC_MISC_MEM:                   group[GRP_SYSTEM]  = 1'b1;
         default:                                    group = '0;
      endcase
      if (opcode[1:0] != 2'b11) begin
         group = '0;
      end
      illegal = (group == '0);
      code    = illegal ? 32'd0 : (32'd1 << opcode[6:2]);
   end

endmodule

// File: rtl/fsm_fetch_dispatch.sv
// Control Unit front end: fetches an instruction word, decodes it, starts one
// execution FSM and waits for its done. Illegal opcodes and watchdog
// timeouts park the block in TRAP until reset.
module fsm_fetch_dispatch
   import cu_pkg::*;
#(
   parameter int WAIT_LIMIT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   fsm_fetch_dispatch_if.master bus,
   output logic                 busy,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [63:0]          instret,
   output state_t               fsm_state
);

   // Watchdog counts 0..WAIT_LIMIT-1; at least 8 bits wide
   localparam int WD_W = ($clog2(WAIT_LIMIT) > 8) ? $clog2(WAIT_LIMIT) : 8;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_LIMIT - 1);

   state_t              state, state_nxt;
   logic [WD_W-1:0]     wd_cnt, wd_nxt;
   logic [31:0]         insn_q, insn_nxt;
   logic [31:0]         code_q, code_nxt;
   logic [NUM_FSM-1:0]  group_q, group_nxt;
   logic [1:0]          cause_q, cause_nxt;
   logic [63:0]         instret_q, instret_nxt;

   logic [31:0]         dec_code;
   logic [NUM_FSM-1:0]  dec_group;
   logic                dec_illegal;

   opcode_group_decode u_decode (
      .opcode  (bus.mem_rdata[6:0]),
      .code    (dec_code),
      .group   (dec_group),
      .illegal (dec_illegal)
   );

   // State and datapath registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         wd_cnt    <= '0;
         insn_q    <= '0;
         code_q    <= '0;
         group_q   <= '0;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
      end else begin
         state     <= state_nxt;
         wd_cnt    <= wd_nxt;
         insn_q    <= insn_nxt;
         code_q    <= code_nxt;
         group_q   <= group_nxt;
         cause_q   <= cause_nxt;
         instret_q <= instret_nxt;
      end
   end

   // Next-state, decode latch, watchdog and retire counter
   always_comb begin
      state_nxt   = state;
      wd_nxt      = wd_cnt;
      insn_nxt    = insn_q;
      code_nxt    = code_q;
      group_nxt   = group_q;
      cause_nxt   = cause_q;
      instret_nxt = instret_q;
      case (state)
         ST_IDLE: begin
            if (run) state_nxt = ST_FETCH_REQ;
         end
         ST_FETCH_REQ: begin
            wd_nxt    = '0;
            state_nxt = ST_FETCH_WAIT;
         end
         ST_FETCH_WAIT: begin
            // A completed read beats a watchdog expiry in the same cycle
            if (bus.mem_done) begin
               insn_nxt  = bus.mem_rdata;
               code_nxt  = dec_code;
               group_nxt = dec_group;
               if (dec_illegal) begin
                  cause_nxt = CAUSE_ILLEGAL;
                  state_nxt = ST_TRAP;
               end else begin
                  state_nxt = ST_DISPATCH;
               end
            end else if (wd_cnt == WD_LAST) begin
               code_nxt  = '0;
               cause_nxt = CAUSE_FETCH_TO;
               state_nxt = ST_TRAP;
            end else begin
               wd_nxt = wd_cnt + 1'b1;
            end
         end
         ST_DISPATCH: begin
            wd_nxt    = '0;
            state_nxt = ST_EXEC_WAIT;
         end
         ST_EXEC_WAIT: begin
            if (bus.fsm_done) begin
               instret_nxt = instret_q + 64'd1;
               state_nxt   = run ? ST_FETCH_REQ : ST_IDLE;
            end else if (wd_cnt == WD_LAST) begin
               code_nxt  = '0;
               cause_nxt = CAUSE_EXEC_TO;
               state_nxt = ST_TRAP;
            end else begin
               wd_nxt = wd_cnt + 1'b1;
            end
         end
         ST_TRAP: begin
            code_nxt = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registers or pure state decodes
   assign bus.mem_start = (state == ST_FETCH_REQ);
   assign bus.start     = (state == ST_DISPATCH) ? group_q : '0;
   assign bus.insn      = insn_q;
   assign bus.code      = code_q;
   assign busy          = (state != ST_IDLE) && (state != ST_TRAP);
   assign trap          = (state == ST_TRAP);
   assign trap_cause    = cause_q;
   assign instret       = instret_q;
   assign fsm_state     = state;

endmodule

// File: tb/tb_fsm_fetch_dispatch.sv
// Directed bench for fsm_fetch_dispatch with WAIT_LIMIT=4.
module tb_fsm_fetch_dispatch;
   import cu_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         run;
   logic         busy;
   logic         trap;
   logic [1:0]   trap_cause;
   logic [63:0]  instret;
   state_t       fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected start pulses, in order
   logic [6:0] exp_q[$];

   fsm_fetch_dispatch_if bus ();

   fsm_fetch_dispatch #(.WAIT_LIMIT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .bus        (bus),
      .busy       (busy),
      .trap       (trap),
      .trap_cause (trap_cause),
      .instret    (instret),
      .fsm_state  (fsm_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Step to just after the next rising edge
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      run           = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_done  = 1'b0;
      bus.fsm_done  = 1'b0;
      tick(2);
      #2 rst_n = 1'b1;
      tick(1);
   endtask

   // From IDLE with run=1: request, then return word with 1-cycle memory
   task automatic fetch(input logic [31:0] word);
      run = 1'b1;
      tick(1);
      check("mem_start_req", bus.mem_start, 1'b1);
      tick(1);
      bus.mem_rdata = word;
      bus.mem_done  = 1'b1;
      tick(1);
      bus.mem_done  = 1'b0;
   endtask

   // Scoreboard: every start pulse must match the next expected one
   always @(negedge clk) begin
      if (rst_n && bus.start != '0) begin
         if (exp_q.size() == 0) check("start_unexpected", bus.start, 7'd0);
         else                   check("start_pulse", bus.start, exp_q.pop_front());
      end
   end

   initial begin
      do_reset();
      check("rst_state", fsm_state, ST_IDLE);
      check("rst_outs", {bus.insn, bus.code}, 64'd0);
      check("rst_ctrl", {bus.start, bus.mem_start, busy, trap, trap_cause}, 12'd0);
      check("rst_instret", instret, 64'd0);

      // BEQ, 1-cycle memory, done 3 cycles after start
      exp_q.push_back(7'b0010000);
      fetch(32'h0020_8463);
      check("beq_state", fsm_state, ST_DISPATCH);
      check("beq_code", bus.code, 32'h0100_0000);
      check("beq_start", bus.start, 7'b0010000);
      tick(2);
      check("beq_hold", {bus.insn, bus.code}, {32'h0020_8463, 32'h0100_0000});
      check("beq_start_low", bus.start, 7'd0);
      bus.fsm_done = 1'b1;
      tick(1);
      bus.fsm_done = 1'b0;
      check("beq_instret", instret, 64'd1);
      check("beq_next_req", bus.mem_start, 1'b1);

      // ADDI with run dropped during EXEC_WAIT
      exp_q.push_back(7'b0000010);
      tick(1);
      bus.mem_rdata = 32'h0010_0093;
      bus.mem_done  = 1'b1;
      tick(1);
      bus.mem_done  = 1'b0;
      check("addi_code", bus.code, 32'h0000_0010);
      check("addi_start", bus.start, 7'b0000010);
      tick(1);
      run = 1'b0;
      tick(1);
      bus.fsm_done = 1'b1;
      tick(1);
      bus.fsm_done = 1'b0;
      check("addi_idle", fsm_state, ST_IDLE);
      check("addi_busy", busy, 1'b0);
      check("addi_instret", instret, 64'd2);
      tick(3);
      check("addi_no_req", {fsm_state == ST_IDLE, bus.mem_start}, 2'b10);

      // Spurious fsm_done in FETCH_WAIT, then fetch timeout
      run = 1'b1;
      tick(2);
      check("fw_state", fsm_state, ST_FETCH_WAIT);
      bus.fsm_done = 1'b1;
      tick(1);
      bus.fsm_done = 1'b0;
      check("fw_spurious", instret, 64'd2);
      tick(2);
      check("fw_still_wait", fsm_state, ST_FETCH_WAIT);
      tick(1);
      check("fto_state", fsm_state, ST_TRAP);
      check("fto_cause", trap_cause, CAUSE_FETCH_TO);
      check("fto_outs", {bus.code, bus.start, busy, trap}, {32'd0, 7'd0, 1'b0, 1'b1});
      bus.mem_done = 1'b1;
      bus.fsm_done = 1'b1;
      tick(3);
      bus.mem_done = 1'b0;
      bus.fsm_done = 1'b0;
      check("trap_absorb", {fsm_state == ST_TRAP, bus.mem_start, instret[7:0]}, {1'b1, 1'b0, 8'd2});

      // Illegal word 0x00000000, then asynchronous reset out of TRAP
      do_reset();
      fetch(32'h0000_0000);
      check("ill_state", fsm_state, ST_TRAP);
      check("ill_cause", trap_cause, CAUSE_ILLEGAL);
      check("ill_code", {bus.code, bus.start}, 39'd0);
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("ill_rst_state", fsm_state, ST_IDLE);
      check("ill_rst_outs", {trap, trap_cause, busy, bus.mem_start, bus.start, bus.code}, 43'd0);
      run = 1'b0;
      #2 rst_n = 1'b1;
      tick(1);

      // Unmapped opcode with [1:0]=11
      fetch(32'h0000_007F);
      check("ill2_cause", {trap, trap_cause}, {1'b1, CAUSE_ILLEGAL});

      // JAL with no fsm_done: execute timeout after 4 EXEC_WAIT cycles
      do_reset();
      exp_q.push_back(7'b0010000);
      fetch(32'h0000_006F);
      check("jal_code", bus.code, 32'h0800_0000);
      tick(4);
      check("jal_wait", fsm_state, ST_EXEC_WAIT);
      tick(1);
      check("eto_state", fsm_state, ST_TRAP);
      check("eto_cause", trap_cause, CAUSE_EXEC_TO);
      check("eto_code", bus.code, 32'd0);

      // LW with fsm_done on the limit cycle: done wins
      do_reset();
      exp_q.push_back(7'b0000100);
      fetch(32'h0000_2083);
      check("lw_code", bus.code, 32'h0000_0001);
      tick(4);
      bus.fsm_done = 1'b1;
      tick(1);
      bus.fsm_done = 1'b0;
      check("lw_limit_done", {fsm_state == ST_FETCH_REQ, trap}, 2'b10);
      check("lw_instret", instret, 64'd1);

      // SW, then asynchronous reset during EXEC_WAIT
      exp_q.push_back(7'b0001000);
      tick(1);
      bus.mem_rdata = 32'h0011_2023;
      bus.mem_done  = 1'b1;
      tick(1);
      bus.mem_done  = 1'b0;
      check("sw_code", bus.code, 32'h0000_0100);
      tick(1);
      check("sw_exec", fsm_state, ST_EXEC_WAIT);
      run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("sw_rst_state", fsm_state, ST_IDLE);
      check("sw_rst_clear", {instret, bus.insn, bus.code, busy}, 129'd0);
      bus.fsm_done = 1'b1;
      #2 rst_n = 1'b1;
      tick(1);
      bus.fsm_done = 1'b0;
      check("sw_late_done", {fsm_state == ST_IDLE, instret[7:0]}, {1'b1, 8'd0});

      tick(2);
      check("sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
